// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit. Detects load-use hazards, applies
// taken-branch flushes, and holds the front of the pipeline while a
// multi-cycle divide occupies EX. Also keeps a saturating count of the
// cycles in which the PC was held.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32  // total cycles a div/divu occupies EX (2..63)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op_id,
  input  logic [4:0]  Rs_id,
  input  logic [4:0]  Rt_id,
  input  logic [5:0]  op_ex,
  input  logic [5:0]  funct_ex,
  input  logic [4:0]  Rt_ex,
  input  logic        Branch_ex,
  output logic        PC_Wr,
  output logic        IFID_Wr,
  output logic        IFID_Flush,
  output logic        IDEX_Wr,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic        div_start,
  output logic        div_busy,
  output logic        div_done,
  output logic [15:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // First hold count loaded on divide start: the start cycle itself is the
  // first of DIV_CYCLES, and the release cycle is the last.
  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [15:0] r_stall_count;

  logic w_load_ex;
  logic w_id_reads_rt;
  logic w_load_use;
  logic w_div_ex;

  // Decode the instruction classes that matter for hazard detection.
  always_comb begin
    w_load_ex     = (op_ex == OP_LW) || (op_ex == OP_LB) || (op_ex == OP_LBU);
    w_id_reads_rt = (op_id == OP_RTYPE) || (op_id == OP_SW) || (op_id == OP_SB) ||
                    (op_id == OP_BEQ) || (op_id == OP_BNE);
    w_load_use    = w_load_ex && (Rt_ex != 5'd0) &&
                    ((Rt_ex == Rs_id) || (w_id_reads_rt && (Rt_ex == Rt_id)));
    w_div_ex      = (op_ex == OP_RTYPE) && ((funct_ex == FN_DIV) || (funct_ex == FN_DIVU));
  end

  // Pipeline control outputs. Priority: reset, divide sequencing, branch
  // flush, load-use stall. Load-use and divide start are ignored while busy.
  always_comb begin
    PC_Wr       = 1'b1;
    IFID_Wr     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Wr     = 1'b1;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    div_start   = 1'b0;
    div_done    = 1'b0;
    div_busy    = (r_state == DIV_BUSY);
    if (rst) begin
      PC_Wr       = 1'b0;
      IFID_Wr     = 1'b0;
      IDEX_Wr     = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      div_busy    = 1'b0;
    end else if (r_state == DIV_BUSY) begin
      if (r_cnt != 6'd0) begin
        PC_Wr       = 1'b0;
        IFID_Wr     = 1'b0;
        IDEX_Wr     = 1'b0;
        EXMEM_Flush = 1'b1;
      end else begin
        div_done = 1'b1;
      end
    end else if (w_div_ex) begin
      div_start   = 1'b1;
      PC_Wr       = 1'b0;
      IFID_Wr     = 1'b0;
      IDEX_Wr     = 1'b0;
      EXMEM_Flush = 1'b1;
    end else if (Branch_ex) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (w_load_use) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  // Divide sequencer: counts down the remaining hold cycles while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_div_ex) begin
            r_cnt   <= CNT_LOAD;
            r_state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= 16'd0;
    end else if (!PC_Wr && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table vectors for the combinational hazard cases
// plus hand-written sequences for divide, reset-abort and saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_id;
  logic [4:0]  Rs_id;
  logic [4:0]  Rt_id;
  logic [5:0]  op_ex;
  logic [5:0]  funct_ex;
  logic [4:0]  Rt_ex;
  logic        Branch_ex;
  logic        PC_Wr, IFID_Wr, IFID_Flush, IDEX_Wr, IDEX_Flush, EXMEM_Flush;
  logic        div_start, div_busy, div_done;
  logic [15:0] stall_count;

  hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .op_id(op_id), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .op_ex(op_ex), .funct_ex(funct_ex), .Rt_ex(Rt_ex), .Branch_ex(Branch_ex),
    .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr), .IFID_Flush(IFID_Flush),
    .IDEX_Wr(IDEX_Wr), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .div_start(div_start), .div_busy(div_busy), .div_done(div_done),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Wr, IDEX_Flush, EXMEM_Flush, div_start, div_busy, div_done}
  localparam logic [8:0] V_DEF   = 9'b110100000;
  localparam logic [8:0] V_STALL = 9'b000110000;
  localparam logic [8:0] V_BR    = 9'b111110000;
  localparam logic [8:0] V_START = 9'b000001100;
  localparam logic [8:0] V_HOLD  = 9'b000001010;
  localparam logic [8:0] V_DONE  = 9'b110100011;
  localparam logic [8:0] V_RST   = 9'b001011000;

  logic [8:0] outs;
  assign outs = {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Wr, IDEX_Flush, EXMEM_Flush,
                 div_start, div_busy, div_done};

  typedef struct {
    string      name;
    logic [5:0] op_id;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] op_ex;
    logic [5:0] funct;
    logic [4:0] rt_ex;
    logic       br;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp_sc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    op_id = 6'b000000; Rs_id = 5'd0; Rt_id = 5'd0;
    op_ex = 6'b000000; funct_ex = 6'b100000; Rt_ex = 5'd0; Branch_ex = 1'b0;
  endtask

  task automatic set_div(input logic [5:0] fn);
    op_ex = 6'b000000; funct_ex = fn; Rt_ex = 5'd0; Branch_ex = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"lw_rs_hit",    6'b000000, 5'd5, 5'd0, 6'b100011, 6'd0, 5'd5, 1'b0, V_STALL};
    vecs[1] = '{"lw_rt0",       6'b000000, 5'd0, 5'd0, 6'b100011, 6'd0, 5'd0, 1'b0, V_DEF};
    vecs[2] = '{"addiu_rt",     6'b001001, 5'd3, 5'd5, 6'b100011, 6'd0, 5'd5, 1'b0, V_DEF};
    vecs[3] = '{"lb_sw_rt",     6'b101011, 5'd1, 5'd7, 6'b100000, 6'd0, 5'd7, 1'b0, V_STALL};
    vecs[4] = '{"lbu_beq_rt",   6'b000100, 5'd2, 5'd9, 6'b100100, 6'd0, 5'd9, 1'b0, V_STALL};
    vecs[5] = '{"rtype_ex",     6'b000000, 5'd5, 5'd5, 6'b000000, 6'b100000, 5'd5, 1'b0, V_DEF};
    vecs[6] = '{"br_over_lu",   6'b000000, 5'd5, 5'd0, 6'b100011, 6'd0, 5'd5, 1'b1, V_BR};
    vecs[7] = '{"br_alone",     6'b000000, 5'd1, 5'd2, 6'b000000, 6'b100000, 5'd3, 1'b1, V_BR};
    vecs[8] = '{"lw_sb_rt",     6'b101000, 5'd2, 5'd4, 6'b100011, 6'd0, 5'd4, 1'b0, V_STALL};
    vecs[9] = '{"lw_lw_rt",     6'b100011, 5'd1, 5'd6, 6'b100011, 6'd0, 5'd6, 1'b0, V_DEF};

    set_nop();
    rst = 1'b1;
    step();
    step();
    chk("rst_outs", 32'(outs), 32'(V_RST));
    chk("rst_sc", 32'(stall_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_outs", 32'(outs), 32'(V_DEF));
    step();
    exp_sc = 16'd0;
    chk("post_rst_sc", 32'(stall_count), 32'(exp_sc));

    // Table of single-cycle hazard vectors in IDLE.
    for (int i = 0; i < 10; i++) begin
      op_id = vecs[i].op_id; Rs_id = vecs[i].rs; Rt_id = vecs[i].rt;
      op_ex = vecs[i].op_ex; funct_ex = vecs[i].funct; Rt_ex = vecs[i].rt_ex;
      Branch_ex = vecs[i].br;
      #1;
      chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      step();
      if (vecs[i].exp[8] == 1'b0) exp_sc = exp_sc + 16'd1;
      chk({vecs[i].name, "_sc"}, 32'(stall_count), 32'(exp_sc));
      set_nop();
    end

    // div, DIV_CYCLES=4: start, hold, hold, done, then idle.
    set_div(6'b011010);
    #1;
    chk("div_c1_start", 32'(outs), 32'(V_START));
    step();
    chk("div_c2_hold", 32'(outs), 32'(V_HOLD));
    step();
    chk("div_c3_hold", 32'(outs), 32'(V_HOLD));
    step();
    chk("div_c4_done", 32'(outs), 32'(V_DONE));
    set_nop();
    #1;
    chk("div_c4_sc", 32'(stall_count), 32'(exp_sc + 16'd3));
    exp_sc = exp_sc + 16'd3;
    step();
    chk("div_c5_idle", 32'(outs), 32'(V_DEF));
    chk("div_c5_sc", 32'(stall_count), 32'(exp_sc));

    // divu aborted by reset on its second busy cycle, then restarted.
    set_div(6'b011011);
    #1;
    chk("divu_start", 32'(outs), 32'(V_START));
    step();
    chk("divu_busy1", 32'(outs), 32'(V_HOLD));
    step();
    chk("divu_busy2", 32'(outs), 32'(V_HOLD));
    rst = 1'b1;
    #1;
    chk("abort_rst_outs", 32'(outs), 32'(V_RST));
    step();
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(div_busy), 32'd0);
    chk("abort_sc", 32'(stall_count), 32'd0);
    chk("restart_start", 32'(outs), 32'(V_START));
    step();
    chk("restart_hold1", 32'(outs), 32'(V_HOLD));
    step();
    chk("restart_hold2", 32'(outs), 32'(V_HOLD));
    step();
    chk("restart_done", 32'(outs), 32'(V_DONE));
    set_nop();
    step();
    chk("restart_sc", 32'(stall_count), 32'd3);
    chk("restart_idle", 32'(outs), 32'(V_DEF));

    // Saturation: hold a load-use hazard for 65540 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    op_id = 6'b000000; Rs_id = 5'd5; Rt_id = 5'd0;
    op_ex = 6'b100011; funct_ex = 6'd0; Rt_ex = 5'd5; Branch_ex = 1'b0;
    #1;
    chk("sat_outs", 32'(outs), 32'(V_STALL));
    repeat (65535) step();
    chk("sat_65535", 32'(stall_count), 32'hFFFF);
    repeat (5) step();
    chk("sat_65540", 32'(stall_count), 32'hFFFF);
    set_nop();
    step();
    chk("sat_hold", 32'(stall_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, total cycles a div/divu occupies EX; legal range 2..63.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op_id  input  6  opcode of instruction in ID.
REQ-005 Rs_id  input  5  rs field of instruction in ID.
REQ-006 Rt_id  input  5  rt field of instruction in ID.
REQ-007 op_ex  input  6  opcode of instruction in EX.
REQ-008 funct_ex  input  6  funct field of instruction in EX.
REQ-009 Rt_ex  input  5  rt (load destination) of instruction in EX.
REQ-010 Branch_ex  input  1  branch/jump in EX resolved taken.
REQ-011 PC_Wr  output  1  1 = PC updates.
REQ-012 IFID_Wr  output  1  1 = IF/ID register loads.
REQ-013 IFID_Flush  output  1  1 = IF/ID loads a bubble.
REQ-014 IDEX_Wr  output  1  1 = ID/EX register loads.
REQ-015 IDEX_Flush  output  1  1 = ID/EX loads a bubble.
REQ-016 EXMEM_Flush  output  1  1 = EX/MEM loads a bubble.
REQ-017 div_start  output  1  one-cycle pulse: divider starts.
REQ-018 div_busy  output  1  FSM in DIV_BUSY.
REQ-019 div_done  output  1  one-cycle pulse: divide result valid, pipeline released.
REQ-020 stall_count  output  16  saturating count of cycles with PC_Wr=0.

Function
REQ-021 Defaults (no hazard): PC_Wr=IFID_Wr=IDEX_Wr=1; all flushes, div_start, div_done 0.
REQ-022 Load in EX: op_ex in {100011 lw, 100000 lb, 100100 lbu}.
REQ-023 ID reads rt: op_id in {000000, 101011 sw, 101000 sb, 000100 beq, 000101 bne}.
REQ-024 Load-use hazard: load in EX, Rt_ex!=0, and (Rt_ex==Rs_id, or Rt_ex==Rt_id with ID reading rt).
REQ-025 Load-use, same cycle (combinational): PC_Wr=0, IFID_Wr=0, IDEX_Flush=1; exactly one bubble per hazard.
REQ-026 Branch_ex=1: IFID_Flush=1, IDEX_Flush=1, PC_Wr=1; overrides load-use.
REQ-027 Divide in EX: op_ex==000000 and funct_ex in {011010, 011011}.
REQ-028 FSM states IDLE, DIV_BUSY; 6-bit counter cnt.
REQ-029 IDLE with divide in EX: div_start=1, PC_Wr=IFID_Wr=IDEX_Wr=0, EXMEM_Flush=1; cnt<=DIV_CYCLES-2; state<=DIV_BUSY.
REQ-030 DIV_BUSY, cnt!=0: same hold/flush outputs, div_start=0; cnt<=cnt-1.
REQ-031 DIV_BUSY, cnt==0: default outputs, div_done=1; state<=IDLE.
REQ-032 Divide occupies EX exactly DIV_CYCLES cycles; DIV_CYCLES-1 hold cycles.
REQ-033 Load-use detection and div_start suppressed while div_busy=1.
REQ-034 stall_count increments every cycle PC_Wr=0, holds at 16'hFFFF.

Reset
REQ-035 rst=1 at edge: state<=IDLE, cnt<=0, stall_count<=0; an in-flight divide is abandoned.
REQ-036 While rst=1: PC_Wr=IFID_Wr=IDEX_Wr=0, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, div_start=div_done=0, div_busy=0.
REQ-037 First cycle after rst deasserts: IDLE; outputs follow REQ-021..REQ-034.

Verification
REQ-038 op_ex=100011, Rt_ex=5, op_id=000000, Rs_id=5 -> PC_Wr=0, IFID_Wr=0, IDEX_Flush=1 for one cycle; stall_count 0->1.
REQ-039 Same with Rt_ex=0, or op_id=001001 (addiu), Rt_id=5, Rs_id=3 -> no stall.
REQ-040 DIV_CYCLES=4, div (funct_ex=011010) in EX -> div_start cycle 1, hold cycles 1-3, div_done cycle 4, IDLE cycle 5; stall_count +3.
REQ-041 Load-use condition and Branch_ex=1 together -> IFID_Flush=IDEX_Flush=1, PC_Wr=1, IFID_Wr=1.
REQ-042 rst=1 on 2nd DIV_BUSY cycle -> div_busy=0, stall_count=0 after edge; divide in EX after release restarts with div_start=1.
REQ-043 Force 65540 stall cycles -> stall_count holds 16'hFFFF.
